// File: rtl/pow_2_energy_acc.sv
// Windowed energy accumulator behind a pipelined squarer.
// Aligns the sample valid to the squarer latency and sums WIN_LEN squares into a valid/ready output.
module pow_2_energy_acc #(
    parameter  int unsigned MUL_LAT = 3,
    parameter  int unsigned WIN_LEN = 16,
    parameter  int unsigned ACC_W   = 20,
    localparam int unsigned CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [15:0]      square_i,
    input  logic             clr_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             sat_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovr_o
);

    typedef enum logic {ACC_IDLE, ACC_RUN}    acc_state_e;
    typedef enum logic {OUT_EMPTY, OUT_FULL}  out_state_e;

    logic [MUL_LAT-1:0] vld_pipe_q, vld_pipe_d, vld_shift;
    acc_state_e         acc_state_q, acc_state_d;
    out_state_e         out_state_q, out_state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_win_q, sat_win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sat_q, sat_d;
    logic               ovr_q, ovr_d;

    logic               arrive;
    logic               complete;
    logic               clamp;
    logic [ACC_W-1:0]   base;
    logic [ACC_W:0]     add_w;
    logic [ACC_W-1:0]   total;

    // Valid delay line matching the squarer latency
    if (MUL_LAT > 1) begin : g_pipe
        assign vld_shift = {vld_pipe_q[MUL_LAT-2:0], valid_i};
    end else begin : g_pipe_one
        assign vld_shift = valid_i;
    end

    always_comb begin
        vld_pipe_d  = vld_shift;
        acc_state_d = acc_state_q;
        out_state_d = out_state_q;
        acc_d       = acc_q;
        sat_win_d   = sat_win_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sat_d       = sat_q;
        ovr_d       = ovr_q;

        arrive   = vld_pipe_q[MUL_LAT-1];
        base     = (acc_state_q == ACC_IDLE) ? '0 : acc_q;
        add_w    = {1'b0, base} + (ACC_W + 1)'(square_i);
        // A clamped window stays clamped until it completes
        clamp    = add_w[ACC_W] | ((acc_state_q == ACC_RUN) & sat_win_q);
        total    = clamp ? '1 : add_w[ACC_W-1:0];
        complete = arrive && (acc_state_q == ACC_RUN) && (cnt_q == CNT_W'(WIN_LEN - 1));

        if (arrive) begin
            if (complete) begin
                acc_d       = '0;
                sat_win_d   = 1'b0;
                cnt_d       = '0;
                acc_state_d = ACC_IDLE;
            end else begin
                acc_d       = total;
                sat_win_d   = clamp;
                cnt_d       = cnt_q + CNT_W'(1);
                acc_state_d = ACC_RUN;
            end
        end

        // Output register: a completion loads over a same-cycle pop, otherwise it is dropped
        case (out_state_q)
            OUT_EMPTY: begin
                if (complete) begin
                    sum_d       = total;
                    sat_d       = clamp;
                    out_state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (complete) begin
                    if (sum_ready_i) begin
                        sum_d = total;
                        sat_d = clamp;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (sum_ready_i) begin
                    out_state_d = OUT_EMPTY;
                end
            end
            default: out_state_d = OUT_EMPTY;
        endcase

        if (clr_i) begin
            vld_pipe_d  = '0;
            acc_state_d = ACC_IDLE;
            out_state_d = OUT_EMPTY;
            acc_d       = '0;
            sat_win_d   = 1'b0;
            cnt_d       = '0;
            sum_d       = '0;
            sat_d       = 1'b0;
            ovr_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            acc_state_q <= ACC_IDLE;
            out_state_q <= OUT_EMPTY;
            acc_q       <= '0;
            sat_win_q   <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            sat_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            acc_state_q <= acc_state_d;
            out_state_q <= out_state_d;
            acc_q       <= acc_d;
            sat_win_q   <= sat_win_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sat_q       <= sat_d;
            ovr_q       <= ovr_d;
        end
    end

    assign sum_o       = sum_q;
    assign sum_valid_o = (out_state_q == OUT_FULL);
    assign sat_o       = sat_q;
    assign cnt_o       = cnt_q;
    assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_pow_2_energy_acc.sv
// Scoreboard bench: two instances (ACC_W=20 and ACC_W=17) share stimulus behind a modelled squarer.
module tb_pow_2_energy_acc;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned WIN_LEN = 4;
    localparam int unsigned ACC_W   = 20;
    localparam int unsigned ACC_WS  = 17;
    localparam int unsigned CNT_W   = $clog2(WIN_LEN + 1);
    localparam int          MAX_S   = (1 << ACC_WS) - 1;

    typedef struct {
        int s20;
        int s17;
        bit sat17;
        int due;
        bit lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic              clr = 1'b0;
    logic              ready = 1'b0;
    logic [7:0]        data = 8'd0;
    logic [15:0]       sq1, sq2, sq3;

    logic [ACC_W-1:0]  sum_a;
    logic              vld_a, sat_a, ovr_a;
    logic [CNT_W-1:0]  cnt_a;
    logic [ACC_WS-1:0] sum_b;
    logic              vld_b, sat_b, ovr_b;
    logic [CNT_W-1:0]  cnt_b;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q[$];

    int   win_n = 0;
    int   exp20 = 0;
    int   exp17 = 0;
    bit   sat17 = 1'b0;
    bit   drop_next = 1'b0;
    bit   lat_en = 1'b0;
    int   t_last;

    pow_2_energy_acc #(.MUL_LAT(MUL_LAT), .WIN_LEN(WIN_LEN), .ACC_W(ACC_W)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .square_i(sq3), .clr_i(clr),
        .sum_o(sum_a), .sum_valid_o(vld_a), .sum_ready_i(ready), .sat_o(sat_a),
        .cnt_o(cnt_a), .ovr_o(ovr_a)
    );

    pow_2_energy_acc #(.MUL_LAT(MUL_LAT), .WIN_LEN(WIN_LEN), .ACC_W(ACC_WS)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .square_i(sq3), .clr_i(clr),
        .sum_o(sum_b), .sum_valid_o(vld_b), .sum_ready_i(ready), .sat_o(sat_b),
        .cnt_o(cnt_b), .ovr_o(ovr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Three-stage squarer model feeding both instances
    always @(posedge clk) begin
        sq1 <= 16'(data) * 16'(data);
        sq2 <= sq1;
        sq3 <= sq2;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d @cyc %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic model_flush();
        win_n = 0;
        exp20 = 0;
        exp17 = 0;
        sat17 = 1'b0;
    endtask

    // One valid sample; the expected window result is queued when its last sample is driven
    task automatic send(input logic [7:0] d);
        int sq;
        exp_t e;
        valid = 1'b1;
        data  = d;
        sq    = int'(d) * int'(d);
        exp20 += sq;
        exp17 += sq;
        if (exp17 > MAX_S) begin
            exp17 = MAX_S;
            sat17 = 1'b1;
        end
        win_n++;
        if (win_n == int'(WIN_LEN)) begin
            if (!drop_next) begin
                e = '{s20: exp20, s17: exp17, sat17: sat17, due: cyc + int'(MUL_LAT) + 1, lat: lat_en};
                q.push_back(e);
            end
            drop_next = 1'b0;
            model_flush();
        end
        tick();
        valid = 1'b0;
    endtask

    task automatic raw(input logic v, input logic [7:0] d);
        valid = v;
        data  = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum_a"}, sum_a, 0);
        check({tag, "_vld_a"}, vld_a, 0);
        check({tag, "_sat_a"}, sat_a, 0);
        check({tag, "_cnt_a"}, cnt_a, 0);
        check({tag, "_ovr_a"}, ovr_a, 0);
        check({tag, "_sum_b"}, sum_b, 0);
        check({tag, "_vld_b"}, vld_b, 0);
        check({tag, "_ovr_b"}, ovr_b, 0);
    endtask

    // Scoreboard: compare held output against queue head, pop on handshake
    always @(negedge clk) begin
        if (vld_a || vld_b) begin
            if (q.size() == 0) begin
                check("unexpected_valid", {30'd0, vld_a, vld_b}, 0);
            end else begin
                check("sum20", sum_a, q[0].s20);
                check("sat20", sat_a, 0);
                check("sum17", sum_b, q[0].s17);
                check("sat17", sat_b, q[0].sat17);
                check("vld_match", vld_b, vld_a);
                if (ready) begin
                    if (q[0].lat) check("latency", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Back-to-back 1..4, single-cycle valid
        ready = 1'b1;
        lat_en = 1'b1;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        idle(3);
        check("t1_vld_on", vld_a, 1);
        idle(1);
        check("t1_vld_off", vld_a, 0);

        // 255 x4 with random gaps, window count stepping
        for (int i = 0; i < int'(WIN_LEN); i++) begin
            send(8'd255);
            idle(3 + int'($urandom_range(0, 3)));
            check("t2_cnt", cnt_a, (i + 1) % int'(WIN_LEN));
        end
        idle(2);

        // Saturating window then a clean one
        send(8'd255); send(8'd255); send(8'd255); send(8'd255);
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        idle(6);

        // Backpressure: second window dropped, first held
        ready = 1'b0;
        lat_en = 1'b0;
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        drop_next = 1'b1;
        send(8'd2); send(8'd2); send(8'd2); send(8'd2);
        idle(4);
        check("t3_ovr_a", ovr_a, 1);
        check("t3_ovr_b", ovr_b, 1);
        check("t3_hold", sum_a, 4);
        ready = 1'b1;
        tick();
        check("t3_vld_drop", vld_a, 0);
        idle(2);

        // Clear mid-window with squares in flight
        raw(1'b1, 8'd9); raw(1'b1, 8'd9); raw(1'b1, 8'd9); raw(1'b1, 8'd9);
        raw(1'b0, 8'd0);
        check("t6_cnt_pre", cnt_a, 2);
        clr = 1'b1;
        raw(1'b1, 8'd9);
        clr = 1'b0;
        check_zero("clr");
        idle(8);
        check("t6_cnt_post", cnt_a, 0);

        // Completion while full with ready high: new sum loads, valid stays up
        ready = 1'b0;
        send(8'd3); send(8'd3); send(8'd3); send(8'd3);
        idle(4);
        send(8'd1); send(8'd2); send(8'd1);
        t_last = cyc;
        send(8'd2);
        idle(int'(MUL_LAT) - 1);
        check("t4_cyc_align", cyc, t_last + int'(MUL_LAT));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t4_vld_stay", vld_a, 1);
        check("t4_sum_new", sum_a, 10);
        check("t4_ovr", ovr_a, 0);
        tick();
        ready = 1'b1;
        idle(2);
        check("t4_vld_off", vld_a, 0);

        // Async reset mid-window, then a fresh window
        lat_en = 1'b1;
        raw(1'b1, 8'd7); raw(1'b1, 8'd7); raw(1'b1, 8'd7); raw(1'b1, 8'd7);
        raw(1'b0, 8'd0);
        rst_n = 1'b0;
        #2;
        check_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        idle(6);
        check_zero("rst_post");
        send(8'd5); send(8'd5); send(8'd5); send(8'd5);
        idle(6);

        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
